// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback-port declarations for the MIPS pipeline (package mips_decls_p).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_decls_p;

   // Depth of the MDU result queue in front of the register-file write port.
   localparam int WB_ARB_DEPTH = 2;
   // Width of an occupancy count that can represent 0..WB_ARB_DEPTH.
   localparam int WB_ARB_CNT_W = $clog2(WB_ARB_DEPTH + 1);

   typedef logic [4:0] regaddr_t;

   // One buffered register write; kill marks a result superseded by a younger pipeline write.
   typedef struct packed {
      regaddr_t    addr;
      logic [31:0] data;
      logic        kill;
   } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small in-order queue of wb_req_t entries with per-entry address-match kill.
// Latency: an entry pushed in cycle t is visible at the head in cycle t+1.
// Backpressure: caller must only push when count < WB_ARB_DEPTH; kill applies to held entries only.
module wb_req_fifo
   import mips_decls_p::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  wb_req_t                 push_dat,
   input  logic                    pop,
   input  logic                    kill_en,
   input  regaddr_t                kill_addr,
   output logic                    head_vld,
   output wb_req_t                 head_dat,
   output logic [WB_ARB_CNT_W-1:0] count
);

   logic [WB_ARB_DEPTH-1:0] vld_q;
   logic [WB_ARB_DEPTH-1:0] vld_d;
   wb_req_t                 ent_q [WB_ARB_DEPTH];
   wb_req_t                 ent_d [WB_ARB_DEPTH];
   logic                    placed;

   // Next queue state: mark killed entries, shift out the head, then place the new entry.
   always_comb begin
      vld_d  = vld_q;
      placed = 1'b0;
      for (int i = 0; i < WB_ARB_DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         // Only entries already held can be superseded; a same-cycle push is younger.
         if (kill_en && vld_q[i] && (ent_q[i].addr == kill_addr)) begin
            ent_d[i].kill = 1'b1;
         end
      end
      if (pop) begin
         for (int i = 0; i < WB_ARB_DEPTH - 1; i++) begin
            ent_d[i] = ent_d[i+1];
            vld_d[i] = vld_d[i+1];
         end
         vld_d[WB_ARB_DEPTH-1] = 1'b0;
      end
      if (push) begin
         for (int i = 0; i < WB_ARB_DEPTH; i++) begin
            if (!placed && !vld_d[i]) begin
               ent_d[i] = push_dat;
               vld_d[i] = 1'b1;
               placed   = 1'b1;
            end
         end
      end
   end

   // Occupancy from the registered valid bits (entries are kept contiguous from slot 0).
   always_comb begin
      count = '0;
      for (int i = 0; i < WB_ARB_DEPTH; i++) begin
         count = count + WB_ARB_CNT_W'(vld_q[i]);
      end
   end

   // Queue state register; payload needs no reset because valid bits gate it.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
      for (int i = 0; i < WB_ARB_DEPTH; i++) begin
         ent_q[i] <= ent_d[i];
      end
   end

   assign head_vld = vld_q[0];
   assign head_dat = ent_q[0];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage and queued MDU results; macro WB_ARB_STARVE_EN adds a starvation guard.
// Latency: pipeline writes pass through combinationally; MDU results are written no earlier than the cycle after acceptance.
// Backpressure: mdu_ready_o drops when the queue is full; with WB_ARB_STARVE_EN, stall_o freezes the pipeline for one cycle to force a drain.
module wb_port_arbiter
   import mips_decls_p::*;
#(
   parameter int MAX_WAIT = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_waddr_i,
   input  logic [31:0] wb_wdata_i,
   input  logic        mdu_valid_i,
   output logic        mdu_ready_o,
   input  logic [4:0]  mdu_waddr_i,
   input  logic [31:0] mdu_wdata_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        stall_o
);

   if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_max_wait_range
      $error("wb_port_arbiter: MAX_WAIT must be within 1..15");
   end

   logic                    pipe_req;
   logic                    head_vld;
   logic                    head_live;
   wb_req_t                 head;
   wb_req_t                 push_dat;
   logic [WB_ARB_CNT_W-1:0] count;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    grant_pipe;
   logic                    grant_head;
   logic                    stall;

   // Writes to $0 are architecturally void, so they never claim the port.
   assign pipe_req  = wb_we_i && (wb_waddr_i != 5'd0);
   assign head_live = head_vld && !head.kill;

   // Readiness looks only at registered occupancy so the MDU never sees a same-cycle pop.
   assign mdu_ready_o = !reset && (count < WB_ARB_CNT_W'(WB_ARB_DEPTH));
   assign fifo_push   = mdu_valid_i && mdu_ready_o && (mdu_waddr_i != 5'd0);
   assign push_dat    = '{addr: mdu_waddr_i, data: mdu_wdata_i, kill: 1'b0};

`ifdef WB_ARB_STARVE_EN
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;

   // Count cycles a live head is passed over; any pop or an empty queue restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= 4'd0;
      end else if (fifo_pop || !head_vld) begin
         wait_cnt <= 4'd0;
      end else if (head_live && !grant_head) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // The forced drain only makes sense for a head that will actually use the port.
   assign stall = !reset && head_live && (wait_cnt == MAX_WAIT_C);
`else
   assign stall = 1'b0;
`endif

   assign stall_o = stall;

   // Port grant: forced drain, then pipeline, then queued MDU head; killed heads retire silently.
   always_comb begin
      grant_pipe = !reset && !stall && pipe_req;
      grant_head = !reset && head_live && (stall || !pipe_req);
      fifo_pop   = !reset && head_vld && (head.kill || grant_head);
      rf_we_o    = 1'b0;
      rf_waddr_o = 5'd0;
      rf_wdata_o = 32'd0;
      if (grant_pipe) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = wb_waddr_i;
         rf_wdata_o = wb_wdata_i;
      end else if (grant_head) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = head.addr;
         rf_wdata_o = head.data;
      end
   end

   wb_req_fifo u_req_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_dat  (push_dat),
      .pop       (fifo_pop),
      .kill_en   (grant_pipe),
      .kill_addr (wb_waddr_i),
      .head_vld  (head_vld),
      .head_dat  (head),
      .count     (count)
   );

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and sequencer for the single register-file write port of the MIPS pipeline. Shares the port between the in-order writeback stage (`result_o`/`regwrite_o` path) and the long-latency multiply/divide unit (MDU), which completes out of band. MDU results are buffered in a 2-entry queue and drained into idle writeback slots. An optional starvation guard freezes the pipeline for one cycle to force an MDU drain.

## Interface
Parameters:
- `MAX_WAIT`, default 4: cycles a queued MDU result may wait before the starvation guard fires (only with `WB_ARB_STARVE_EN`); legal range 1–15.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_we_i` in 1: writeback stage write request (`regwrite_o` of writeback).
- `wb_waddr_i` in 5: writeback destination register.
- `wb_wdata_i` in 32: writeback data (`result_o`).
- `mdu_valid_i` in 1: MDU result valid.
- `mdu_ready_o` out 1: arbiter can accept an MDU result.
- `mdu_waddr_i` in 5: MDU destination register.
- `mdu_wdata_i` in 32: MDU result data.
- `rf_we_o` out 1: register-file write enable.
- `rf_waddr_o` out 5: register-file write address.
- `rf_wdata_o` out 32: register-file write data.
- `stall_o` out 1: freeze IF..WB for this cycle (always 0 without `WB_ARB_STARVE_EN`).

## Operation
- Effective pipeline request: `wb_we_i && wb_waddr_i != 0`. Writes to `$0` are dropped and leave the port free.
- MDU handshake: a transfer occurs on a cycle where `mdu_valid_i && mdu_ready_o`. `mdu_ready_o = (count < 2)` from registered state; it does not depend on same-cycle pops. An MDU result with `mdu_waddr_i == 0` is accepted but never enqueued.
- Queue: 2-entry FIFO of {addr, data, kill}.
- Grant priority, per cycle:
  1. Forced drain (`stall_o`=1): head written; pipeline request ignored because the pipeline is frozen and re-presents next cycle.
  2. Effective pipeline request: pipeline written.
  3. Head valid and not killed: head written and popped.
- Killed head: popped without using the port, in any cycle, including one where the pipeline writes.
- WAW rule: when the pipeline writes register R, every queued entry with addr R gets kill=1 in that cycle. An incoming MDU result with addr R in that same cycle is enqueued *not* killed, because it is younger.
- Port outputs are combinational from the grant. When nothing is granted, `rf_we_o`=0 and addr/data are 0.
- Starvation counter `wait_cnt` (4 bits):
  - Increments each cycle a live head exists and is not written.
  - Clears on head pop or when the queue is empty.
  - `stall_o = (wait_cnt == MAX_WAIT)`.

## Timing
- Pipeline path: zero latency, combinational pass-through.
- MDU path: result accepted in cycle t is written earliest in cycle t+1; with a free port each cycle, sustained throughput is 1 per cycle.
- `stall_o` is a function of registered state only, is asserted for exactly one cycle per firing, and `wait_cnt` returns to 0 the next cycle.
- Reset asserted (any cycle, including mid-drain):
  - Queue emptied; `wait_cnt`=0.
  - While `reset` is high: `mdu_ready_o`=0, `rf_we_o`=0, `stall_o`=0, addr/data=0.
  - First cycle after deassertion: `mdu_ready_o`=1.
  - Queued results are lost.

## Configuration
- `WB_ARB_STARVE_EN` defined: `wait_cnt` and the forced-drain grant are compiled in.
- Undefined: strict pipeline priority; `stall_o` is tied to 0; `wait_cnt` is absent. An MDU result may wait indefinitely, and the MDU is back-pressured via `mdu_ready_o`.

## Structure
- Additions to `mips_decls_p`:
  - `WB_ARB_DEPTH = 2`.
  - `typedef logic [4:0] regaddr_t`.
  - `typedef struct packed {regaddr_t addr; logic [31:0] data; logic kill;} wb_req_t`.
- Sub-module `wb_req_fifo`: 2-entry FIFO of `wb_req_t` with push, pop, count, and a per-entry address-match kill input.
- Grant logic and `wait_cnt` stay in `wb_port_arbiter`.

## Test plan
- Idle pipeline: MDU pushes (r8, 0x1234) at cycle 5 → `rf_we_o`=1, addr 8, data 0x1234 at cycle 6; `mdu_ready_o` stays 1.
- Contention: pipeline writes r3..r6 on four consecutive cycles while MDU pushes r9, r10, r11 → r9 and r10 accepted, `mdu_ready_o`=0 on the third push, r9 then r10 drained in the first idle cycles, in order.
- WAW: queue holds (r5, 0xAAAA); pipeline writes (r5, 0xBBBB) → head killed and popped with no port use; r5 = 0xBBBB.
- `$0`: pipeline `wb_we_i`=1, addr 0, while the queue holds r7 → `rf_waddr_o`=7 is written the same cycle.
- Starvation (`WB_ARB_STARVE_EN`, `MAX_WAIT`=4): pipeline writes every cycle, one MDU entry queued at cycle 0 → `stall_o`=1 in cycle 5 only, MDU entry written in cycle 5, pipeline write re-presented in cycle 6. Without the macro, `stall_o` stays 0 and the entry waits.
- Reset mid-operation: two entries queued, `reset` high for 1 cycle → no `rf_we_o`, `mdu_ready_o`=0 during reset and 1 after, queue empty.
